// File: rtl/parity_check_sequencer.sv
// Self-test sequencer for a 3-input even/odd parity stage.
// Sweeps codes 0..7, samples synchronized Fev/Fodd, reports verdict.
module parity_check_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       Fev,
  input  logic       Fodd,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [2:0] code, code_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] err_n;
  logic [2:0] ff_n;
  logic       busy_n, done_n, pass_n;
  logic       fev_s1, fev_s2;
  logic       fodd_s1, fodd_s2;
  logic       exp_od, exp_ev, miss;

  assign exp_od = ^code;
  assign exp_ev = ~exp_od;
  assign miss   = (fev_s2 != exp_ev) ||
                  (fodd_s2 != exp_od);

  assign A = code[0];
  assign B = code[1];
  assign C = code[2];

  always_comb begin
    state_n = state;
    code_n  = code;
    cnt_n   = cnt;
    err_n   = err_count;
    ff_n    = first_fail;
    busy_n  = busy;
    done_n  = 1'b0;
    pass_n  = pass;
    unique case (state)
      IDLE: begin
        code_n = 3'd0;
        busy_n = 1'b0;
        if (start) begin
          state_n = SETTLE;
          cnt_n   = RELOAD;
          busy_n  = 1'b1;
          err_n   = 4'd0;
          ff_n    = 3'd0;
          pass_n  = 1'b0;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_n = IDLE;
          code_n  = 3'd0;
          cnt_n   = 4'd0;
          busy_n  = 1'b0;
          pass_n  = 1'b0;
        end else if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          if (miss) begin
            err_n = err_count + 4'd1;
            // err_count still zero means this is the sweep's first miss
            if (err_count == 4'd0)
              ff_n = code;
          end
          if (code == 3'd7) begin
            state_n = DONE;
            code_n  = 3'd0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_n == 4'd0);
          end else begin
            code_n = code + 3'd1;
            cnt_n  = RELOAD;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        if (abort)
          pass_n = 1'b0;
      end
      default: begin
        state_n = IDLE;
        code_n  = 3'd0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      code       <= 3'd0;
      cnt        <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 4'd0;
      first_fail <= 3'd0;
      fev_s1     <= 1'b0;
      fev_s2     <= 1'b0;
      fodd_s1    <= 1'b0;
      fodd_s2    <= 1'b0;
    end else begin
      state      <= state_n;
      code       <= code_n;
      cnt        <= cnt_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      err_count  <= err_n;
      first_fail <= ff_n;
      fev_s1     <= Fev;
      fev_s2     <= fev_s1;
      fodd_s1    <= Fodd;
      fodd_s2    <= fodd_s1;
    end
  end

endmodule

// File: doc/parity_check_sequencer.md
Name: parity_check_sequencer

Overview:
- Clocked test sequencer wrapped around the 3-input even/odd parity generator stage.
- Upstream role: drives the generator's A, B, C inputs through all 8 codes.
- Downstream role: samples the generator's Fev and Fodd outputs and checks them.
- Produces a pass/fail verdict, an error count and the first failing code, for bench and board self-test of the parity stage.

Parameters:
- SETTLE_CYCLES, 4: cycles each code is held before sampling; legal range 3..15; includes the 2-cycle input synchronizer.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  cancel a sweep in progress.
- Fev  input  1  even-parity output of the parity stage (asynchronous).
- Fodd  input  1  odd-parity output of the parity stage (asynchronous).
- A  output  1  code bit 0 (LSB) to the parity stage.
- B  output  1  code bit 1 to the parity stage.
- C  output  1  code bit 2 (MSB) to the parity stage.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  high if the last sweep had zero errors; held until next start.
- err_count  output  4  number of failing codes in the last sweep (0..8).
- first_fail  output  3  first failing code; 0 when none.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; A=B=C=0; busy=0; done=0; pass=0; err_count=0; first_fail=0; synchronizer flops=0; settle counter=0.
- Input sync: Fev and Fodd each pass through a 2-flop synchronizer. All checks use the synchronized values only.
- Expected values for code k={C,B,A}: Fev=~^k (even number of ones), Fodd=^k.
- A code fails if synchronized Fev or Fodd differs from its expected value. This includes both high and both low.
- Each code counts at most once.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - busy=0; A,B,C hold 0.
  - start=1 -> next cycle SETTLE with code=0, cnt=SETTLE_CYCLES-1, busy=1.
  - On start: err_count, first_fail and pass are cleared.
- SETTLE:
  - Code is driven on {C,B,A}; cnt decrements each cycle.
  - When cnt==0: check the synchronized pair this cycle.
  - On a failure: err_count++. If this is the first error of the sweep, first_fail=code.
  - Then, if code==7 -> DONE next cycle; otherwise code++ and cnt reloads to SETTLE_CYCLES-1.
- DONE:
  - done=1 for exactly one cycle; pass=(err_count==0); busy=0; {C,B,A}=0.
  - Then IDLE.
- Timing: start sampled at cycle 0 -> sample instants at cycles SETTLE_CYCLES*(k+1) for code k -> done pulse at cycle 8*SETTLE_CYCLES+1.
- start while busy: ignored.
- start high continuously: a new sweep begins in the cycle after DONE returns to IDLE.
- abort:
  - Takes priority over start and over sampling.
  - In SETTLE or DONE: next cycle IDLE; {C,B,A}=0; busy=0; no done pulse; pass=0.
  - err_count and first_fail keep their partial values.
  - abort in IDLE has no effect.
- Abort and start in the same IDLE cycle: abort has no effect in IDLE, so the sweep starts.
- Reset mid-sweep: immediate return to reset values; no done pulse.
- err_count never exceeds 8, so no saturation logic is needed.
- All outputs are registered.

Test Plan:
- SETTLE_CYCLES=4, correct parity model (Fev=XNOR, Fodd=XOR), start pulse at cycle 0:
  - {C,B,A} steps 0..7, each held 4 cycles; done pulses at cycle 33.
  - pass=1, err_count=0, first_fail=0.
- Model with Fev and Fodd swapped -> err_count=8, first_fail=0, pass=0.
- Fodd stuck at 0, Fev correct -> codes 1,2,4,7 fail; err_count=4, first_fail=1, pass=0.
- Both outputs forced high at code 5 only -> err_count=1, first_fail=5. Also check that a Fev glitch lasting 1 cycle right after the code change (not near the sample instant) is not counted.
- abort asserted while code=3 -> busy=0 next cycle, {C,B,A}=0, no done pulse, pass=0. A following start runs a full clean sweep with pass=1.
- start re-pulsed at code 2 is ignored (sweep still finishes at cycle 33). rst_n pulled low at code 6 -> all outputs immediately 0, state IDLE.
